// File: rtl/npc_pkg.sv
// npc_pkg: types and constants shared across the NPC core.
// Fetch FSM encoding, bus response codes and the reset PC.
package npc_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_RESP = 2'd1,
        S_OUT  = 2'd2
    } ifu_state_t;

    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [31:0] DEF_RST_PC = 32'h8000_0000;
    localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/ifu.sv
// ifu: non-pipelined instruction fetch, one outstanding read.
// Holds the PC, fetches a word, hands it to idu on valid/ready.
import npc_pkg::*;

module ifu #(
    parameter int unsigned         DATA_LEN = 32,
    parameter logic [DATA_LEN-1:0] RST_PC   = DATA_LEN'(DEF_RST_PC)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                redirect_valid,
    input  logic [DATA_LEN-1:0] redirect_pc,
    output logic                ifu_arvalid,
    input  logic                ifu_arready,
    output logic [DATA_LEN-1:0] ifu_araddr,
    input  logic                ifu_rvalid,
    output logic                ifu_rready,
    input  logic [31:0]         ifu_rdata,
    input  logic [1:0]          ifu_rresp,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [31:0]         inst,
    output logic [DATA_LEN-1:0] PC,
    output logic [DATA_LEN-1:0] PC_S,
    output logic                unusual_flag
);

    ifu_state_t          state_q, state_d;
    logic [DATA_LEN-1:0] pc_q, pc_d;
    logic [DATA_LEN-1:0] addr_q, addr_d;
    logic [DATA_LEN-1:0] pc_s;
    logic [31:0]         inst_q, inst_d;
    logic                kill_q, kill_d;
    logic                flag_q, flag_d;
    logic                misaligned;
    logic                ar_req;
    logic                ar_stall;

    assign misaligned = pc_q[1:0] != 2'b00;
    assign pc_s       = pc_q + DATA_LEN'(INST_BYTES);

    // A killed request keeps its old address until accepted.
    assign ar_req   = (state_q == S_REQ) && (kill_q || !misaligned);
    assign ar_stall = ar_req && !ifu_arready;

    assign ifu_arvalid  = rst_n && ar_req;
    assign ifu_araddr   = addr_q;
    assign ifu_rready   = state_q == S_RESP;
    assign inst_valid   = state_q == S_OUT;
    assign inst         = inst_q;
    assign PC           = pc_q;
    assign PC_S         = pc_s;
    assign unusual_flag = flag_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        inst_d  = inst_q;
        flag_d  = flag_q;
        unique case (state_q)
            S_REQ: begin
                if (ar_req) begin
                    if (ifu_arready) begin
                        state_d = S_RESP;
                    end
                    if (redirect_valid) begin
                        kill_d = 1'b1;
                    end
                end else if (!redirect_valid) begin
                    state_d = S_OUT;
                    inst_d  = '0;
                    flag_d  = 1'b1;
                end
            end
            S_RESP: begin
                if (ifu_rvalid) begin
                    if (kill_q || redirect_valid) begin
                        state_d = S_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        state_d = S_OUT;
                        flag_d  = ifu_rresp != RESP_OKAY;
                        inst_d  = (ifu_rresp == RESP_OKAY) ? ifu_rdata : '0;
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    state_d = S_REQ;
                    pc_d    = pc_s;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end
    end

    assign addr_d = ar_stall ? addr_q : pc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            pc_q    <= RST_PC;
            addr_q  <= RST_PC;
            inst_q  <= '0;
            kill_q  <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            kill_q  <= kill_d;
            flag_q  <= flag_d;
        end
    end

endmodule

// File: tb/tb_ifu.sv
// tb_ifu: directed vectors, corner sequences and a randomized
// run against a stream-level model of the fetch unit.
module tb_ifu;

    localparam logic [31:0] RST = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifu_arvalid;
    logic        ifu_arready = 1'b0;
    logic [31:0] ifu_araddr;
    logic        ifu_rvalid = 1'b0;
    logic        ifu_rready;
    logic [31:0] ifu_rdata = '0;
    logic [1:0]  ifu_rresp = '0;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] PC_S;
    logic        unusual_flag;

    ifu dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_araddr(ifu_araddr), .ifu_rvalid(ifu_rvalid),
        .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata),
        .ifu_rresp(ifu_rresp), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst(inst), .PC(PC),
        .PC_S(PC_S), .unusual_flag(unusual_flag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // slave-side state and knobs
    int          cyc = 0;
    int          ar_count = 0;
    int          ar_cyc = 0;
    logic [31:0] last_ar = '0;
    bit          rnd_mode = 0;
    int          fix_wait = 0;
    bit          ovr_en = 0;
    logic [31:0] ovr_data = '0;
    logic [1:0]  ovr_resp = '0;
    bit          sl_pend = 0;
    logic [31:0] sl_addr = '0;
    int          sl_wait = 0;
    bit          ar_held = 0;
    logic [31:0] ar_hold_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    function automatic bit is_fault(input logic [31:0] a);
        return a[6:2] == 5'd7;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!inst_valid && n < 40) begin
            tick();
            n++;
        end
        chk(name, 32'(inst_valid), 32'd1);
    endtask

    task automatic wait_ar(input int base, input string name);
        int n = 0;
        while (ar_count == base && n < 40) begin
            tick();
            n++;
        end
        chk(name, 32'(ar_count != base), 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_arvalid"}, 32'(ifu_arvalid), 32'd0);
        chk({tag, "_rready"}, 32'(ifu_rready), 32'd0);
        chk({tag, "_ivalid"}, 32'(inst_valid), 32'd0);
        chk({tag, "_pc"}, PC, RST);
        chk({tag, "_pcs"}, PC_S, RST + 32'd4);
        chk({tag, "_inst"}, inst, 32'd0);
        chk({tag, "_flag"}, 32'(unusual_flag), 32'd0);
    endtask

    // AXI4-Lite read slave with protocol checks
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            sl_pend = 0;
            ar_held = 0;
            ifu_rvalid = 1'b0;
            ifu_arready = 1'b0;
        end else begin
            ifu_rvalid = sl_pend && sl_wait == 0;
            if (ovr_en) begin
                ifu_rdata = ovr_data;
                ifu_rresp = ovr_resp;
            end else begin
                ifu_rdata = mem_word(sl_addr);
                ifu_rresp = is_fault(sl_addr) ? 2'b10 : 2'b00;
            end
            ifu_arready = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (ifu_arvalid) begin
                chk("ar_align", 32'(ifu_araddr[1:0]), 32'd0);
                if (ar_held) chk("ar_stable", ifu_araddr, ar_hold_addr);
            end
            if (ifu_rvalid && ifu_rready) sl_pend = 0;
            else if (sl_pend && sl_wait != 0) sl_wait--;
            if (ifu_arvalid && ifu_arready) begin
                chk("one_outstanding", 32'(sl_pend), 32'd0);
                sl_pend = 1;
                sl_addr = ifu_araddr;
                sl_wait = rnd_mode ? int'($urandom_range(0, 3)) : fix_wait;
                ar_count++;
                ar_cyc = cyc;
                last_ar = ifu_araddr;
                ar_held = 0;
            end else begin
                ar_held = ifu_arvalid;
                ar_hold_addr = ifu_araddr;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [31:0] exp_inst;
        logic        exp_flag;
        int          exp_ar;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [31:0] h_inst, h_pc, h_pcs;
        logic        h_flag;
        logic [31:0] exp_pc;
        bit          presented, seen;
        int          base, n, delivered, idle;

        vecs[0] = '{32'h8000_0400, 32'h1234_5678, 2'b00, 32'h1234_5678, 1'b0, 1};
        vecs[1] = '{32'h8000_0002, 32'h1111_1111, 2'b00, 32'h0, 1'b1, 0};
        vecs[2] = '{32'h8000_0003, 32'h2222_2222, 2'b00, 32'h0, 1'b1, 0};
        vecs[3] = '{32'h8000_0500, 32'hdead_beef, 2'b10, 32'h0, 1'b1, 1};
        vecs[4] = '{32'h8000_0504, 32'hcafe_f00d, 2'b01, 32'h0, 1'b1, 1};
        vecs[5] = '{32'h8000_0508, 32'hffff_ffff, 2'b11, 32'h0, 1'b1, 1};
        vecs[6] = '{32'hffff_fffc, 32'h0000_0013, 2'b00, 32'h13, 1'b0, 1};
        vecs[7] = '{32'h0000_0000, 32'ha5a5_a5a5, 2'b00, 32'ha5a5_a5a5, 1'b0, 1};

        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        inst_ready = 1'b0;

        // reset state and first fetch
        tick();
        tick();
        chk_reset("rst");
        ovr_en = 1;
        ovr_data = 32'h0010_0093;
        ovr_resp = 2'b00;
        fix_wait = 0;
        rst_n = 1'b1;
        #1;
        chk("rel_arvalid", 32'(ifu_arvalid), 32'd1);
        chk("rel_araddr", ifu_araddr, RST);
        wait_valid("first_valid");
        chk("first_latency", 32'(cyc - ar_cyc), 32'd2);
        chk("first_inst", inst, 32'h0010_0093);
        chk("first_pc", PC, RST);
        chk("first_pcs", PC_S, RST + 32'd4);
        chk("first_flag", 32'(unusual_flag), 32'd0);

        // back-pressure
        h_inst = inst;
        h_pc = PC;
        base = ar_count;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(inst_valid), 32'd1);
            chk("bp_inst", inst, h_inst);
            chk("bp_pc", PC, h_pc);
            chk("bp_no_ar", 32'(ar_count), 32'(base));
        end
        ovr_en = 0;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        wait_ar(base, "bp_ar_seen");
        chk("bp_next_ar", last_ar, RST + 32'd4);
        wait_valid("bp_valid2");
        chk("bp_inst2", inst, mem_word(RST + 32'd4));

        // redirect while waiting for the response
        fix_wait = 4;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        n = 0;
        while (!ifu_rready && n < 20) begin
            tick();
            n++;
        end
        chk("resp_reached", 32'(ifu_rready), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        base = ar_count;
        seen = 0;
        n = 0;
        while (ar_count == base && n < 40) begin
            if (inst_valid) seen = 1;
            tick();
            n++;
        end
        chk("kill_no_valid", 32'(seen), 32'd0);
        chk("kill_next_ar", last_ar, 32'h8000_0100);
        fix_wait = 0;
        wait_valid("kill_valid");
        chk("kill_pc", PC, 32'h8000_0100);
        chk("kill_inst", inst, mem_word(32'h8000_0100));

        // redirect wins over inst_ready
        base = ar_count;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0200;
        inst_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        chk("rdr_drop", 32'(inst_valid), 32'd0);
        wait_ar(base, "rdr_ar_seen");
        chk("rdr_ar", last_ar, 32'h8000_0200);
        wait_valid("rdr_valid");
        chk("rdr_pc", PC, 32'h8000_0200);

        // table of single fetches including faults
        for (int i = 0; i < 8; i++) begin
            ovr_en = 1;
            ovr_data = vecs[i].data;
            ovr_resp = vecs[i].resp;
            base = ar_count;
            redirect_valid = 1'b1;
            redirect_pc = vecs[i].pc;
            tick();
            redirect_valid = 1'b0;
            wait_valid("vec_valid");
            chk("vec_inst", inst, vecs[i].exp_inst);
            chk("vec_flag", 32'(unusual_flag), 32'(vecs[i].exp_flag));
            chk("vec_pc", PC, vecs[i].pc);
            chk("vec_pcs", PC_S, vecs[i].pc + 32'd4);
            chk("vec_ar", 32'(ar_count - base), 32'(vecs[i].exp_ar));
        end
        ovr_en = 0;

        // reset in the middle of a fetch
        fix_wait = 5;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        n = 0;
        while (!ifu_rready && n < 20) begin
            tick();
            n++;
        end
        chk("mid_resp", 32'(ifu_rready), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset("mid");
        tick();
        tick();
        base = ar_count;
        rst_n = 1'b1;
        wait_ar(base, "mid_ar_seen");
        chk("mid_ar", last_ar, RST);

        // randomized run against a stream model
        rnd_mode = 1;
        exp_pc = RST;
        presented = 0;
        delivered = 0;
        idle = 0;
        h_inst = '0;
        h_pcs = '0;
        h_flag = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (inst_valid) begin
                if (!presented) begin
                    chk("rnd_pc", PC, exp_pc);
                    chk("rnd_pcs", PC_S, exp_pc + 32'd4);
                    if (exp_pc[1:0] != 2'b00 || is_fault(exp_pc)) begin
                        chk("rnd_inst", inst, 32'd0);
                        chk("rnd_flag", 32'(unusual_flag), 32'd1);
                    end else begin
                        chk("rnd_inst", inst, mem_word(exp_pc));
                        chk("rnd_flag", 32'(unusual_flag), 32'd0);
                    end
                    presented = 1;
                    h_inst = inst;
                    h_pcs = PC_S;
                    h_flag = unusual_flag;
                    delivered++;
                    idle = 0;
                end else begin
                    chk("rnd_hold_inst", inst, h_inst);
                    chk("rnd_hold_pc", PC, exp_pc);
                    chk("rnd_hold_pcs", PC_S, h_pcs);
                    chk("rnd_hold_flag", 32'(unusual_flag), 32'(h_flag));
                end
            end
            inst_ready = $urandom_range(0, 3) != 0;
            redirect_valid = $urandom_range(0, 19) == 0;
            if ($urandom_range(0, 7) == 0)
                redirect_pc = RST | 32'($urandom_range(0, 1023));
            else
                redirect_pc = RST | (32'($urandom_range(0, 255)) << 2);
            if (redirect_valid) begin
                exp_pc = redirect_pc;
                presented = 0;
            end else if (inst_valid && inst_ready) begin
                exp_pc = exp_pc + 32'd4;
                presented = 0;
            end
            idle++;
            if (idle > 150) begin
                chk("rnd_progress", 32'(idle), 32'd150);
                break;
            end
            tick();
        end
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        chk("rnd_delivered", 32'(delivered > 50), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
